// File: rtl/dmem_arbiter.sv
// Two-port arbiter/controller in front of the word-addressed data memory.
// Optional round-robin arbitration: define DMEM_ARB_ROUND_ROBIN_EN (default is fixed priority, port 0 wins).
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_we,
  input  logic [1:0]        p0_req_size,
  input  logic              p0_req_unsigned,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [31:0]       p0_req_wdata,
  output logic              p0_rsp_valid,
  input  logic              p0_rsp_ready,
  output logic [31:0]       p0_rsp_rdata,
  output logic              p0_rsp_err,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_we,
  input  logic [1:0]        p1_req_size,
  input  logic              p1_req_unsigned,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [31:0]       p1_req_wdata,
  output logic              p1_rsp_valid,
  input  logic              p1_rsp_ready,
  output logic [31:0]       p1_rsp_rdata,
  output logic              p1_rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_mask,
  output logic              mem_cs_n,
  output logic              mem_wr_en_n,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata
);

  generate
    if (DATA_W != 32) begin : g_bad_data_w
      $error("dmem_arbiter: DATA_W must be 32");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t      r_state, w_next;
  logic        r_last_grant;
  logic        r_port, r_we, r_uns, r_err;
  logic [1:0]  r_size, r_addr_lo;
  logic [31:0] r_rdata;

  logic              w_prefer_p1, w_gnt0, w_gnt1, w_accept, w_bad, w_rsp_ready;
  logic              w_we, w_uns;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata, w_lane_wdata, w_shift, w_load;
  logic [3:0]        w_mask;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  assign w_prefer_p1 = ~r_last_grant;
`else
  assign w_prefer_p1 = r_last_grant & 1'b0;
`endif

  assign w_gnt0   = p0_req_valid & (~p1_req_valid | ~w_prefer_p1);
  assign w_gnt1   = p1_req_valid & ~w_gnt0;
  assign w_accept = (r_state == S_IDLE) & (w_gnt0 | w_gnt1);

  assign p0_req_ready = (r_state == S_IDLE) & w_gnt0;
  assign p1_req_ready = (r_state == S_IDLE) & w_gnt1;

  assign w_we    = w_gnt1 ? p1_req_we       : p0_req_we;
  assign w_size  = w_gnt1 ? p1_req_size     : p0_req_size;
  assign w_uns   = w_gnt1 ? p1_req_unsigned : p0_req_unsigned;
  assign w_addr  = w_gnt1 ? p1_req_addr     : p0_req_addr;
  assign w_wdata = w_gnt1 ? p1_req_wdata    : p0_req_wdata;

  assign w_bad = (w_size == 2'd3) |
                 ((w_size == 2'd1) & w_addr[0]) |
                 ((w_size == 2'd2) & (w_addr[1:0] != 2'b00));

  always_comb begin
    w_mask       = 4'b1111;
    w_lane_wdata = w_wdata;
    case (w_size)
      2'd0: begin
        w_mask       = 4'b0001 << w_addr[1:0];
        w_lane_wdata = {4{w_wdata[7:0]}};
      end
      2'd1: begin
        w_mask       = 4'b0011 << w_addr[1:0];
        w_lane_wdata = {2{w_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_shift = mem_rdata >> {r_addr_lo, 3'b000};

  always_comb begin
    w_load = w_shift;
    case (r_size)
      2'd0: w_load = r_uns ? {24'd0, w_shift[7:0]}  : {{24{w_shift[7]}}, w_shift[7:0]};
      2'd1: w_load = r_uns ? {16'd0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      default: ;
    endcase
  end

  assign w_rsp_ready = r_port ? p1_rsp_ready : p0_rsp_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = w_bad ? S_RESP : S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   if (w_rsp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_we         <= 1'b0;
      r_uns        <= 1'b0;
      r_size       <= 2'd0;
      r_addr_lo    <= 2'd0;
      r_err        <= 1'b0;
      r_rdata      <= '0;
      mem_cs_n     <= 1'b1;
      mem_wr_en_n  <= 1'b1;
      mem_rd_en    <= 1'b0;
      mem_mask     <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_last_grant <= w_gnt1;
            r_port       <= w_gnt1;
            r_we         <= w_we;
            r_uns        <= w_uns;
            r_size       <= w_size;
            r_addr_lo    <= w_addr[1:0];
            r_rdata      <= '0;
            r_err        <= w_bad;
            // Bad requests skip ACCESS entirely, so memory is never selected.
            if (!w_bad) begin
              mem_cs_n    <= 1'b0;
              mem_rd_en   <= ~w_we;
              mem_wr_en_n <= ~w_we;
              mem_mask    <= w_mask;
              mem_addr    <= {w_addr[ADDR_W-1:2], 2'b00};
              mem_wdata   <= w_lane_wdata;
            end
          end
        end
        S_ACCESS: begin
          r_rdata     <= r_we ? 32'd0 : w_load;
          mem_cs_n    <= 1'b1;
          mem_wr_en_n <= 1'b1;
          mem_rd_en   <= 1'b0;
          mem_mask    <= '0;
          mem_addr    <= '0;
          mem_wdata   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign p0_rsp_valid = (r_state == S_RESP) & ~r_port;
  assign p1_rsp_valid = (r_state == S_RESP) &  r_port;
  assign p0_rsp_rdata = p0_rsp_valid ? r_rdata : 32'd0;
  assign p1_rsp_rdata = p1_rsp_valid ? r_rdata : 32'd0;
  assign p0_rsp_err   = p0_rsp_valid & r_err;
  assign p1_rsp_err   = p1_rsp_valid & r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small negedge-clocked memory model.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req_valid = 0, p0_req_ready, p0_req_we = 0, p0_req_unsigned = 0;
  logic [1:0]  p0_req_size = 0;
  logic [31:0] p0_req_addr = 0, p0_req_wdata = 0;
  logic        p0_rsp_valid, p0_rsp_ready = 0, p0_rsp_err;
  logic [31:0] p0_rsp_rdata;
  logic        p1_req_valid = 0, p1_req_ready, p1_req_we = 0, p1_req_unsigned = 0;
  logic [1:0]  p1_req_size = 0;
  logic [31:0] p1_req_addr = 0, p1_req_wdata = 0;
  logic        p1_rsp_valid, p1_rsp_ready = 0, p1_rsp_err;
  logic [31:0] p1_rsp_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_cs_n, mem_wr_en_n, mem_rd_en;
  logic [31:0] mem_rdata = 0;
  logic [31:0] mem [0:63];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_size(p0_req_size), .p0_req_unsigned(p0_req_unsigned), .p0_req_addr(p0_req_addr),
    .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready),
    .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_size(p1_req_size), .p1_req_unsigned(p1_req_unsigned), .p1_req_addr(p1_req_addr),
    .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
    .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_cs_n(mem_cs_n),
    .mem_wr_en_n(mem_wr_en_n), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata)
  );

  // Memory model: reads and writes happen at the negedge inside the access cycle.
  always @(negedge clk) begin
    if (!mem_cs_n) begin
      if (!mem_wr_en_n)
        for (int b = 0; b < 4; b++)
          if (mem_mask[b]) mem[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
      if (mem_rd_en) mem_rdata = mem[mem_addr[7:2]];
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int port, input logic v, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
    if (port == 0) begin
      p0_req_valid = v; p0_req_we = we; p0_req_size = sz; p0_req_unsigned = uns;
      p0_req_addr = a; p0_req_wdata = wd;
    end else begin
      p1_req_valid = v; p1_req_we = we; p1_req_size = sz; p1_req_unsigned = uns;
      p1_req_addr = a; p1_req_wdata = wd;
    end
  endtask

  // Issues one request and completes its response; lat = 99 means it never responded.
  task automatic run_req(input int port, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] o_addr, output logic [31:0] o_wdata,
                         output logic [3:0] o_mask, output logic o_rd_en, output logic o_wr_en_n,
                         output int cs_cnt, output int wr_cnt, output int lat,
                         output logic [31:0] o_rdata, output logic o_err);
    int n;
    logic rdy, vld;
    o_addr = 0; o_wdata = 0; o_mask = 0; o_rd_en = 0; o_wr_en_n = 1;
    cs_cnt = 0; wr_cnt = 0; o_rdata = 32'hxxxxxxxx; o_err = 1'bx;
    set_req(port, 1, we, sz, uns, a, wd);
    #1;
    n = 0;
    rdy = (port == 0) ? p0_req_ready : p1_req_ready;
    while (!rdy && n < 20) begin
      tick; n++;
      rdy = (port == 0) ? p0_req_ready : p1_req_ready;
    end
    tick;
    set_req(port, 0, we, sz, uns, a, wd);
    lat = 1;
    vld = (port == 0) ? p0_rsp_valid : p1_rsp_valid;
    while (!vld && lat < 20) begin
      if (!mem_cs_n) begin
        cs_cnt++;
        o_addr = mem_addr; o_wdata = mem_wdata; o_mask = mem_mask;
        o_rd_en = mem_rd_en; o_wr_en_n = mem_wr_en_n;
      end
      if (!mem_wr_en_n) wr_cnt++;
      tick; lat++;
      vld = (port == 0) ? p0_rsp_valid : p1_rsp_valid;
    end
    if (!mem_cs_n) cs_cnt++;
    if (!mem_wr_en_n) wr_cnt++;
    if (!vld) lat = 99;
    o_rdata = (port == 0) ? p0_rsp_rdata : p1_rsp_rdata;
    o_err   = (port == 0) ? p0_rsp_err   : p1_rsp_err;
    if (port == 0) p0_rsp_ready = 1; else p1_rsp_ready = 1;
    tick;
    p0_rsp_ready = 0; p1_rsp_ready = 0;
  endtask

  logic [31:0] a_addr, a_wdata, r_data;
  logic [3:0]  a_mask;
  logic        a_rd, a_wrn, r_err;
  int          cs_n_cnt, wr_n_cnt, lat;

  task automatic test_reset;
    reset = 1; tick; tick; reset = 0; #1;
    checks++; if (p0_rsp_valid !== 0 || p1_rsp_valid !== 0) begin errors++; $display("FAIL reset_rsp_valid: got %b%b expected 00", p0_rsp_valid, p1_rsp_valid); end
    checks++; if (p0_rsp_rdata !== 0 || p0_rsp_err !== 0) begin errors++; $display("FAIL reset_rsp_data: got %h/%b expected 0/0", p0_rsp_rdata, p0_rsp_err); end
    checks++; if ({mem_cs_n, mem_wr_en_n, mem_rd_en} !== 3'b110) begin errors++; $display("FAIL reset_mem_ctl: got %b expected 110", {mem_cs_n, mem_wr_en_n, mem_rd_en}); end
    checks++; if (mem_mask !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin errors++; $display("FAIL reset_mem_bus: got %h/%h/%h expected 0/0/0", mem_mask, mem_addr, mem_wdata); end
    checks++; if (p0_req_ready !== 0 || p1_req_ready !== 0) begin errors++; $display("FAIL reset_req_ready: got %b%b expected 00", p0_req_ready, p1_req_ready); end
  endtask

  task automatic test_word_load;
    run_req(0, 0, 2'd2, 0, 32'h8, 0, a_addr, a_wdata, a_mask, a_rd, a_wrn, cs_n_cnt, wr_n_cnt, lat, r_data, r_err);
    checks++; if (a_addr !== 32'h8) begin errors++; $display("FAIL wload_addr: got %h expected 00000008", a_addr); end
    checks++; if (cs_n_cnt !== 1 || a_rd !== 1 || a_wrn !== 1) begin errors++; $display("FAIL wload_ctl: got cs=%0d rd=%b wrn=%b expected 1 1 1", cs_n_cnt, a_rd, a_wrn); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL wload_latency: got %0d expected 2", lat); end
    checks++; if (r_data !== 32'hDEADBEEF || r_err !== 0) begin errors++; $display("FAIL wload_rsp: got %h/%b expected deadbeef/0", r_data, r_err); end
  endtask

  task automatic test_byte_store;
    run_req(1, 1, 2'd0, 0, 32'h13, 32'h000000A5, a_addr, a_wdata, a_mask, a_rd, a_wrn, cs_n_cnt, wr_n_cnt, lat, r_data, r_err);
    checks++; if (a_addr !== 32'h10 || a_mask !== 4'b1000) begin errors++; $display("FAIL bstore_addr_mask: got %h/%b expected 00000010/1000", a_addr, a_mask); end
    checks++; if (a_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL bstore_wdata: got %h expected a5a5a5a5", a_wdata); end
    checks++; if (wr_n_cnt !== 1 || a_rd !== 0) begin errors++; $display("FAIL bstore_we_cycles: got wr=%0d rd=%b expected 1 0", wr_n_cnt, a_rd); end
    checks++; if (r_data !== 0 || r_err !== 0 || lat !== 2) begin errors++; $display("FAIL bstore_rsp: got %h/%b lat %0d expected 0/0 lat 2", r_data, r_err, lat); end
    checks++; if (mem[4] !== 32'hA5223344) begin errors++; $display("FAIL bstore_mem: got %h expected a5223344", mem[4]); end
  endtask

  task automatic test_subword_load;
    logic [31:0] addrs [5];
    logic [1:0]  sizes [5];
    logic        unss  [5];
    logic [31:0] exps  [5];
    addrs = '{32'h21, 32'h22, 32'h22, 32'h23, 32'h20};
    sizes = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
    unss  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exps  = '{32'h0000007F, 32'hFFFF80F0, 32'h000080F0, 32'hFFFFFF80, 32'h00000001};
    for (int i = 0; i < 5; i++) begin
      run_req(0, 0, sizes[i], unss[i], addrs[i], 0, a_addr, a_wdata, a_mask, a_rd, a_wrn, cs_n_cnt, wr_n_cnt, lat, r_data, r_err);
      checks++; if (r_data !== exps[i] || r_err !== 0 || lat !== 2) begin errors++; $display("FAIL subload_%0d: got %h/%b lat %0d expected %h/0 lat 2", i, r_data, r_err, lat, exps[i]); end
    end
    run_req(0, 0, 2'd1, 0, 32'h22, 0, a_addr, a_wdata, a_mask, a_rd, a_wrn, cs_n_cnt, wr_n_cnt, lat, r_data, r_err);
    checks++; if (a_mask !== 4'b1100 || a_addr !== 32'h20) begin errors++; $display("FAIL subload_mask: got %b/%h expected 1100/00000020", a_mask, a_addr); end
  endtask

  task automatic test_misaligned;
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    addrs = '{32'h6, 32'h21, 32'h0};
    sizes = '{2'd2, 2'd1, 2'd3};
    for (int i = 0; i < 3; i++) begin
      run_req(0, 0, sizes[i], 0, addrs[i], 0, a_addr, a_wdata, a_mask, a_rd, a_wrn, cs_n_cnt, wr_n_cnt, lat, r_data, r_err);
      checks++; if (r_err !== 1 || r_data !== 0) begin errors++; $display("FAIL misalign_rsp_%0d: got %h/%b expected 0/1", i, r_data, r_err); end
      checks++; if (cs_n_cnt !== 0 || lat !== 1) begin errors++; $display("FAIL misalign_timing_%0d: got cs=%0d lat %0d expected 0 lat 1", i, cs_n_cnt, lat); end
    end
  endtask

  task automatic test_back_to_back;
    int gnt [4];
    int cyc [4];
    int g, both;
    logic [31:0] p0_data;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    int exp_gnt [4] = '{0, 1, 0, 1};
`else
    int exp_gnt [4] = '{0, 0, 0, 0};
`endif
    reset = 1; tick; reset = 0;
    g = 0; both = 0; p0_data = 32'h0;
    p0_rsp_ready = 1; p1_rsp_ready = 1;
    set_req(0, 1, 0, 2'd2, 0, 32'h8, 0);
    set_req(1, 1, 0, 2'd2, 0, 32'h20, 0);
    #1;
    for (int c = 0; c < 30 && g < 4; c++) begin
      if (p0_req_ready && p1_req_ready) both++;
      if (p0_req_ready) begin gnt[g] = 0; cyc[g] = c; g++; end
      else if (p1_req_ready) begin gnt[g] = 1; cyc[g] = c; g++; end
      if (p0_rsp_valid && p0_data == 0) p0_data = p0_rsp_rdata;
      checks++; if (p1_req_addr !== 32'h20 || p1_req_valid !== 1) begin errors++; $display("FAIL b2b_p1_hold: got %h/%b expected 00000020/1", p1_req_addr, p1_req_valid); end
      tick;
    end
    set_req(0, 0, 0, 2'd2, 0, 32'h8, 0);
    set_req(1, 0, 0, 2'd2, 0, 32'h20, 0);
    checks++; if (g !== 4) begin errors++; $display("FAIL b2b_grant_count: got %0d expected 4", g); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (i < g && gnt[i] !== exp_gnt[i]) begin errors++; $display("FAIL b2b_grant_%0d: got %0d expected %0d", i, gnt[i], exp_gnt[i]); end
    end
    checks++; if (g >= 2 && cyc[1] - cyc[0] !== 3) begin errors++; $display("FAIL b2b_spacing: got %0d expected 3", cyc[1] - cyc[0]); end
    checks++; if (both !== 0) begin errors++; $display("FAIL b2b_dual_ready: got %0d expected 0", both); end
    checks++; if (p0_data !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_p0_data: got %h expected deadbeef", p0_data); end
    repeat (4) tick;
    p0_rsp_ready = 0; p1_rsp_ready = 0;
  endtask

  task automatic test_reset_in_access;
    int n;
    set_req(0, 1, 1, 2'd2, 0, 32'h30, 32'h12345678);
    #1;
    n = 0;
    while (!p0_req_ready && n < 20) begin tick; n++; end
    tick;
    set_req(0, 0, 1, 2'd2, 0, 32'h30, 32'h12345678);
    checks++; if (mem_cs_n !== 0 || mem_wr_en_n !== 0) begin errors++; $display("FAIL rst_access_entry: got cs=%b wrn=%b expected 0 0", mem_cs_n, mem_wr_en_n); end
    reset = 1; tick; reset = 0;
    checks++; if (mem_cs_n !== 1 || mem_wr_en_n !== 1 || p0_rsp_valid !== 0) begin errors++; $display("FAIL rst_access_abort: got cs=%b wrn=%b vld=%b expected 1 1 0", mem_cs_n, mem_wr_en_n, p0_rsp_valid); end
    checks++; if (mem[12] !== 32'h12345678) begin errors++; $display("FAIL rst_access_commit: got %h expected 12345678", mem[12]); end
    set_req(1, 1, 0, 2'd2, 0, 32'h8, 0);
    #1;
    checks++; if (p1_req_ready !== 1 || p0_rsp_valid !== 0) begin errors++; $display("FAIL rst_access_idle: got rdy=%b vld=%b expected 1 0", p1_req_ready, p0_rsp_valid); end
    tick;
    set_req(1, 0, 0, 2'd2, 0, 32'h8, 0);
    tick;
    for (int i = 0; i < 5; i++) begin
      checks++; if (p1_rsp_valid !== 1 || p1_rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL resp_hold_%0d: got %b/%h expected 1/deadbeef", i, p1_rsp_valid, p1_rsp_rdata); end
      tick;
    end
    reset = 1; tick; reset = 0;
    checks++; if (p1_rsp_valid !== 0 || p1_rsp_rdata !== 0) begin errors++; $display("FAIL resp_reset_drop: got %b/%h expected 0/0", p1_rsp_valid, p1_rsp_rdata); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[2] = 32'hDEADBEEF;
    mem[4] = 32'h11223344;
    mem[8] = 32'h80F07F01;
    test_reset();
    test_word_load();
    test_byte_store();
    test_subword_load();
    test_misaligned();
    test_back_to_back();
    test_reset_in_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
